vga_fb_arbiter: RTL and testbench

Arbiter for the single-port framebuffer RAM shared by VGA scanout and a pixel writer (drawing engine or CPU port). It sits beside the VGA sync generator and uses that generator's 25 MHz pixel strobe and h/v counters. Scanout gets a guaranteed read slot on every active-video pixel strobe. Every other cycle goes to the writer through a req/ack handshake. The block also tracks frame alignment and flags address and frame errors.

---
 rtl/vga_fb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: one guaranteed scanout read per active pixel strobe,
// writer req/ack on all remaining cycles, plus frame-alignment and address error flags.
module vga_fb_arbiter #(
  parameter int H_VIDEO = 640,
  parameter int V_VIDEO = 480,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              frame_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  localparam int FRAME_PIX = H_VIDEO * V_VIDEO;
  localparam logic [ADDR_W:0] FRAME_PIX_C = (ADDR_W+1)'(FRAME_PIX);

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_SCAN     = 1'b1
  } state_t;

  state_t              state_r, state_nx_s;
  logic [ADDR_W:0]     scan_addr_r;
  logic [RD_LAT:0]     rv_ce_r;
  logic [RD_LAT:0]     rv_scan_r;
  logic                wr_ack_r, wr_err_r, frame_err_r, mem_we_r, pix_valid_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r, pix_data_r;
  logic                sof_s, active_s, scan_slot_s, grant_s, wr_in_range_s;

  assign sof_s         = pix_ce && (h_count == 10'd0) && (v_count == 10'd0);
  assign active_s      = (h_count < 10'(H_VIDEO)) && (v_count < 10'(V_VIDEO));
  assign wr_in_range_s = ({1'b0, wr_addr} < FRAME_PIX_C);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_WAIT_SOF;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and slot decode; the SOF strobe is itself the scan slot for address 0.
  always_comb begin
    state_nx_s  = state_r;
    scan_slot_s = 1'b0;
    grant_s     = 1'b0;
    case (state_r)
      ST_WAIT_SOF: begin
        if (sof_s) begin
          state_nx_s  = ST_SCAN;
          scan_slot_s = 1'b1;
        end else begin
          state_nx_s  = ST_WAIT_SOF;
          scan_slot_s = 1'b0;
        end
      end
      ST_SCAN: begin
        state_nx_s = ST_SCAN;
        if (pix_ce && active_s) begin
          scan_slot_s = 1'b1;
        end else begin
          scan_slot_s = 1'b0;
        end
      end
      default: begin
        state_nx_s  = ST_WAIT_SOF;
        scan_slot_s = 1'b0;
      end
    endcase
    // The ack cycle itself never grants, capping the writer at one write per 2 clks.
    if (!scan_slot_s && wr_req && !wr_ack_r) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // RAM port, scan address counter, handshake and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_addr_r <= '0;
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
      wr_ack_r    <= 1'b0;
      wr_err_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      wr_ack_r <= grant_s;
      if (scan_slot_s) begin
        mem_we_r <= 1'b0;
        if (sof_s) begin
          mem_addr_r  <= '0;
          scan_addr_r <= (ADDR_W+1)'(1);
        end else begin
          mem_addr_r  <= scan_addr_r[ADDR_W-1:0];
          scan_addr_r <= scan_addr_r + (ADDR_W+1)'(1);
        end
      end else if (grant_s) begin
        if (wr_in_range_s) begin
          mem_we_r    <= 1'b1;
          mem_addr_r  <= wr_addr;
          mem_wdata_r <= wr_data;
        end else begin
          mem_we_r <= 1'b0;
          wr_err_r <= 1'b1;
        end
      end else begin
        mem_we_r <= 1'b0;
      end
      if (sof_s && (state_r == ST_SCAN) && (scan_addr_r != FRAME_PIX_C)) begin
        frame_err_r <= 1'b1;
      end else begin
        frame_err_r <= frame_err_r;
      end
    end
  end

  // Read-valid pipe: every strobe is tracked so blanked strobes also zero the pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_ce_r     <= '0;
      rv_scan_r   <= '0;
      pix_valid_r <= 1'b0;
      pix_data_r  <= '0;
    end else begin
      rv_ce_r   <= {rv_ce_r[RD_LAT-1:0], pix_ce};
      rv_scan_r <= {rv_scan_r[RD_LAT-1:0], scan_slot_s};
      if (rv_ce_r[RD_LAT]) begin
        if (rv_scan_r[RD_LAT]) begin
          pix_valid_r <= 1'b1;
          pix_data_r  <= mem_rdata;
        end else begin
          pix_valid_r <= 1'b0;
          pix_data_r  <= '0;
        end
      end else begin
        pix_valid_r <= pix_valid_r;
        pix_data_r  <= pix_data_r;
      end
    end
  end

  assign wr_ack    = wr_ack_r;
  assign wr_err    = wr_err_r;
  assign frame_err = frame_err_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign pix_data  = pix_data_r;
  assign pix_valid = pix_valid_r;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter on a reduced 8x4 active raster (12x6 total) with a
// synchronous RAM model; a frame-level behavioural model is checked every clock.
module tb_vga_fb_arbiter;

  localparam int H_VIDEO   = 8;
  localparam int V_VIDEO   = 4;
  localparam int H_TOTAL   = 12;
  localparam int V_TOTAL   = 6;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 1;
  localparam int FRAME_PIX = H_VIDEO * V_VIDEO;
  localparam int FRAME_CLK = 2 * H_TOTAL * V_TOTAL;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pix_ce = 1'b0;
  logic [9:0]        h_count = 10'd0;
  logic [9:0]        v_count = 10'd4;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack, wr_err, frame_err, mem_we, pix_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, pix_data;
  logic [DATA_W-1:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  vga_fb_arbiter #(
    .H_VIDEO(H_VIDEO), .V_VIDEO(V_VIDEO), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .h_count(h_count), .v_count(v_count),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_err(wr_err), .frame_err(frame_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data),
    .pix_valid(pix_valid)
  );

  initial forever #5 clk = ~clk;

  // RAM model: contents start as addr[7:0], one clock read latency.
  logic [DATA_W-1:0] ram [0:63];
  initial for (int i = 0; i < 64; i++) ram[i] = DATA_W'(i);
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Sync generator: strobe every 2nd clk, counters advance per strobe.
  int gh = 0, gv = 4;
  bit ce_phase = 1'b1;
  bit gen_short = 1'b0;
  initial forever begin
    @(negedge clk);
    if (ce_phase) begin
      pix_ce  = 1'b1;
      h_count = 10'(gh);
      v_count = 10'(gv);
      gh++;
      if (gh == H_TOTAL) begin
        gh = 0;
        gv++;
        if (gv == (gen_short ? V_VIDEO - 1 : V_TOTAL)) gv = 0;
      end
    end else begin
      pix_ce = 1'b0;
    end
    ce_phase = !ce_phase;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model.
  typedef struct {
    int          due;
    bit          scan;
    logic [7:0]  data;
  } pend_t;
  pend_t pq[$];
  logic [7:0] exp_mem [0:63];
  int  cyc = 0;
  int  reads = 0;
  bit  scanning = 1'b0;
  bit  e_ack, e_werr, e_ferr, e_we, e_pv;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0] e_wd, e_pd;

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pq.delete();
        scanning = 1'b0; reads = 0;
        e_ack = 1'b0; e_werr = 1'b0; e_ferr = 1'b0; e_we = 1'b0; e_pv = 1'b0;
        e_addr = '0; e_wd = '0; e_pd = '0;
      end else begin
        bit sof, act, scan, grant;
        int pa;
        sof  = pix_ce && h_count == 10'd0 && v_count == 10'd0;
        act  = (int'(h_count) < H_VIDEO) && (int'(v_count) < V_VIDEO);
        scan = pix_ce && act && (scanning || sof);
        pa   = int'(v_count) * H_VIDEO + int'(h_count);
        if (pq.size() > 0 && pq[0].due == cyc) begin
          pend_t e;
          e = pq.pop_front();
          e_pv = e.scan;
          e_pd = e.scan ? e.data : 8'h00;
        end
        if (pix_ce) pq.push_back('{cyc + RD_LAT + 1, scan, scan ? exp_mem[pa % 64] : 8'h00});
        if (sof && scanning && reads != FRAME_PIX) e_ferr = 1'b1;
        if (sof) begin reads = 0; scanning = 1'b1; end
        if (scan) reads++;
        grant = !scan && wr_req && !e_ack;
        if (scan) begin
          e_we = 1'b0; e_addr = ADDR_W'(pa);
        end else if (grant) begin
          if (int'(wr_addr) < FRAME_PIX) begin
            e_we = 1'b1; e_addr = wr_addr; e_wd = wr_data; exp_mem[wr_addr] = wr_data;
          end else begin
            e_we = 1'b0; e_werr = 1'b1;
          end
        end else begin
          e_we = 1'b0;
        end
        e_ack = grant;
      end
      #1;
      chk("wr_ack", wr_ack, e_ack);
      chk("wr_err", wr_err, e_werr);
      chk("frame_err", frame_err, e_ferr);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("pix_valid", pix_valid, e_pv);
      chk("pix_data", pix_data, e_pd);
    end
  end

  task automatic wait_pix(input int h, input int v);
    bit hit = 1'b0;
    for (int n = 0; n < 4 * FRAME_CLK && !hit; n++) begin
      @(posedge clk);
      hit = pix_ce && h_count == 10'(h) && v_count == 10'(v);
    end
    if (!hit) begin
      miscompares++;
      $display("FAIL wait_pix timeout for (%0d,%0d)", h, v);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit we_lit);
    bit got = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk);
      #1;
      got = wr_ack;
    end
    if (!got) begin
      miscompares++;
      $display("FAIL wr_ack timeout addr %0d", a);
    end else begin
      chk("lit_we_on_ack", mem_we, we_lit);
      if (we_lit) begin
        chk("lit_addr_on_ack", mem_addr, a);
        chk("lit_wdata_on_ack", mem_wdata, d);
      end
    end
    @(negedge clk);
    wr_req = 1'b0;
    @(posedge clk);
    #1;
    chk("lit_ack_pulse", wr_ack, 1'b0);
  endtask

  initial begin
    int vcount, maxa;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("lit_reset_pix_valid", pix_valid, 1'b0);
    chk("lit_reset_mem_addr", mem_addr, 0);

    // Idle frame: count pixel-valid clocks and highest scan address.
    wait_pix(0, 0);
    vcount = 0; maxa = 0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(posedge clk);
      #1;
      if (pix_valid) vcount++;
      if (int'(mem_addr) > maxa) maxa = int'(mem_addr);
    end
    chk("lit_valid_clks", vcount, 2 * FRAME_PIX);
    chk("lit_max_scan_addr", maxa, FRAME_PIX - 1);
    chk("lit_frame_err_clean", frame_err, 1'b0);

    // Pixel (5,1) -> address 13 -> 0x0D, two clks after its strobe.
    wait_pix(5, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lit_pix_5_1_valid", pix_valid, 1'b1);
    chk("lit_pix_5_1_data", pix_data, 8'h0D);

    // Write during active video, then read it back at (4,2).
    do_write(6'd20, 8'hAA, 1'b1);
    wait_pix(4, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lit_readback_20", pix_data, 8'hAA);

    // Out-of-range write is acked and dropped.
    do_write(6'd40, 8'h55, 1'b0);
    chk("lit_wr_err_set", wr_err, 1'b1);

    // Writes during vertical blanking.
    wait_pix(0, 4);
    do_write(6'd25, 8'h3C, 1'b1);
    do_write(6'd26, 8'hC3, 1'b1);

    // Mid-frame reset.
    wait_pix(4, 2);
    chk("lit_wr_err_sticky", wr_err, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("lit_wr_err_cleared", wr_err, 1'b0);
    chk("lit_frame_err_cleared", frame_err, 1'b0);
    wait_pix(0, 0);
    #1;
    chk("lit_restart_addr0", mem_addr, 0);
    wait_pix(0, 0);
    #1;
    chk("lit_frame_err_after_reset", frame_err, 1'b0);

    // Short frame (one line missing) must flag frame_err, which then sticks.
    @(negedge clk);
    gen_short = 1'b1;
    wait_pix(0, 0);
    @(negedge clk);
    gen_short = 1'b0;
    chk("lit_frame_err_short", frame_err, 1'b1);
    wait_pix(0, 0);
    #1;
    chk("lit_frame_err_sticky", frame_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
